machine_int_ctrl: RTL and testbench
===================================

// Module: machine_int_ctrl
// PURPOSE
//  Memory-mapped machine-level interrupt controller for the RV32I trap pipeline.
//  Owns mtime/mtimecmp and MSIP (CLINT-style) and a NUM_EXT-source external gateway with claim/complete.
//  Drives the core's machineTimerInterrupt / machineSoftwareInterrupt / machineExternalInterrupt inputs.
//  Sits on the data bus beside data_mem; the core decodes sel from data_adr.
// PARAMETERS
//  NUM_EXT   8   number of external interrupt sources (1..31); source ID = index+1
//  PRESCALE  1   clk cycles per mtime increment (>=1)
// PORTS
//  clk                       in   1   system clock, all state on posedge
//  rst                       in   1   synchronous, active-high reset
//  sel                       in   1   bus select for this block (address decoded upstream)
//  adr                       in   5   word-aligned register offset (adr[1:0] ignored)
//  d_in                      in   32  write data
//  mrd                       in   1   read strobe
//  mwr                       in   1   write strobe
//  d_out                     out  32  read data, combinational
//  ext_irq                   in   NUM_EXT  level-sensitive external requests, synchronous to clk
//  machineTimerInterrupt     out  1   registered, mtime >= mtimecmp
//  machineSoftwareInterrupt  out  1   registered, MSIP[0]
//  machineExternalInterrupt  out  1   registered, |(pending & enable)
// BEHAVIOUR
//  Register map (offset): 0x00 MSIP (bit0 RW), 0x04 MTIMECMP_LO, 0x08 MTIMECMP_HI, 0x0C MTIME_LO,
//   0x10 MTIME_HI, 0x14 EXT_PENDING (RO), 0x18 EXT_ENABLE (RW), 0x1C CLAIM (R) / COMPLETE (W).
//  Unmapped offsets: read 0, write ignored. d_out = 0 when !(sel & mrd).
//  Reset: MSIP=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, enable=0, all gateways IDLE, prescaler=0,
//   all three interrupt outputs 0.
//  Timer: prescaler counts 0..PRESCALE-1; on wrap mtime += 1 (64-bit, wraps to 0 from all-ones).
//   Bus write to MTIME_LO/HI in the same cycle as a tick: write wins, that tick is dropped.
//   machineTimerInterrupt = unsigned 64-bit compare, registered: 1-cycle latency after mtime/mtimecmp change.
//  Software: MSIP write takes effect at the edge; machineSoftwareInterrupt follows one cycle later.
//  Gateway FSM per source i: IDLE -> PENDING when ext_irq[i]=1;
//   PENDING -> INSERVICE on claim of ID i+1; INSERVICE -> IDLE on COMPLETE write of d_in[4:0]==i+1.
//   Requests are ignored in PENDING and INSERVICE (no re-pend until complete).
//   COMPLETE of a source not INSERVICE, or ID 0 / >NUM_EXT: ignored.
//  EXT_PENDING[i] = (state==PENDING); pending sets regardless of enable.
//  CLAIM read: returns lowest-index pending&enabled source as ID (i+1), or 0 if none.
//   Side effect at the edge of the sel&mrd cycle only: that source -> INSERVICE.
//   A claim with result 0 has no effect. mrd held N cycles = N claims.
//  Simultaneous claim and complete of different sources: both act.
//   Complete of source i while ext_irq[i]=1: IDLE this edge, PENDING next edge.
//  mrd & mwr both asserted: write performed, read data valid, claim side effect suppressed.
//  rst mid-operation (any state): all FSMs to IDLE; in-service work is discarded, no completion needed.
// CONFIGURATION
//  MTIME_SNAPSHOT_EN defined: reading MTIME_LO latches mtime[63:32] into a shadow register;
//   MTIME_HI reads return the shadow (tear-free 64-bit read). Shadow reset 0.
//   Writes to MTIME_HI update live mtime and the shadow.
//  Not defined: MTIME_HI reads return live mtime[63:32]; no shadow register exists.
// TESTING
//  1 rst=1 two cycles -> all irq outputs 0; MTIMECMP_LO/HI read 0xFFFFFFFF; MTIME reads 0 at release.
//  2 PRESCALE=1, write CMP_HI=0 then CMP_LO=20 -> timer irq rises the cycle after mtime==20;
//    write CMP_HI=1 -> irq 0 one cycle later.
//  3 write MSIP=1 -> machineSoftwareInterrupt=1 next cycle; write MSIP=0 -> 0 next cycle.
//  4 ENABLE=0x05, pulse ext_irq[0] and ext_irq[2] one cycle -> ext irq=1;
//    CLAIM reads 1, then 3, then 0; irq=0 after second claim.
//    COMPLETE 1 with ext_irq[0] high -> PENDING bit0 set two edges later.
//  5 ENABLE=0, ext_irq[3]=1 -> EXT_PENDING=0x08, ext irq stays 0, CLAIM reads 0;
//    write ENABLE=0x08 -> irq=1 next cycle.
//  6 claim source 2 (INSERVICE), assert rst one cycle -> EXT_PENDING=0, ext irq=0;
//    ext_irq[1] high -> pends again without COMPLETE.
//    With MTIME_SNAPSHOT_EN: mtime=0x0_FFFFFFFF, read LO, wait 3 ticks, read HI -> 0.

Source files
------------

// File: rtl/machine_int_ctrl.sv
// Machine-level interrupt controller: CLINT-style mtime/mtimecmp/MSIP plus a
// NUM_EXT-source external gateway with claim/complete, on a simple select/strobe bus.
// Optional build macro: MTIME_SNAPSHOT_EN (MTIME_LO reads latch mtime[63:32] into a
// shadow that MTIME_HI reads return, so a LO-then-HI read pair cannot tear).
module machine_int_ctrl #(
  parameter int unsigned NUM_EXT  = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic [4:0]         adr,
  input  logic [31:0]        d_in,
  input  logic               mrd,
  input  logic               mwr,
  output logic [31:0]        d_out,
  input  logic [NUM_EXT-1:0] ext_irq,
  output logic               machineTimerInterrupt,
  output logic               machineSoftwareInterrupt,
  output logic               machineExternalInterrupt
);

  // Word index of each register (adr[4:2])
  localparam logic [2:0] RegMsip   = 3'd0;
  localparam logic [2:0] RegCmpLo  = 3'd1;
  localparam logic [2:0] RegCmpHi  = 3'd2;
  localparam logic [2:0] RegTimeLo = 3'd3;
  localparam logic [2:0] RegTimeHi = 3'd4;
  localparam logic [2:0] RegPend   = 3'd5;
  localparam logic [2:0] RegEnable = 3'd6;
  localparam logic [2:0] RegClaim  = 3'd7;

  // Gateway states
  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StPending   = 2'd1;
  localparam logic [1:0] StInService = 2'd2;

  localparam logic [31:0] PreMax = 32'(PRESCALE - 1);

  logic [31:0]        r_presc;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_msip;
  logic [NUM_EXT-1:0] r_enable;
  logic [1:0]         r_gw [NUM_EXT];
  logic [1:0]         w_gw_next [NUM_EXT];
  logic               r_timer_irq;
  logic               r_sw_irq;
  logic               r_ext_irq;

  logic [2:0]         w_reg;
  logic               w_wr;
  logic               w_rd;
  logic               w_tick;
  logic [NUM_EXT-1:0] w_pending;
  logic [4:0]         w_claim_id;
  logic               w_claim_fire;
  logic               w_cmpl;
  logic [31:0]        w_time_hi_rd;
  logic               w_unused_adr;

  assign w_reg        = adr[4:2];
  assign w_unused_adr = ^adr[1:0];
  assign w_wr         = sel & mwr;
  assign w_rd         = sel & mrd;
  assign w_tick       = (r_presc == PreMax);
  // A combined read/write cycle never claims
  assign w_claim_fire = w_rd & ~mwr & (w_reg == RegClaim) & (w_claim_id != 5'd0);
  assign w_cmpl       = w_wr & (w_reg == RegClaim);

  // Pending vector and lowest-index pending&enabled source ID
  always_comb begin
    w_claim_id = 5'd0;
    for (int i = 0; i < NUM_EXT; i++) begin
      w_pending[i] = (r_gw[i] == StPending);
    end
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (w_pending[i] && r_enable[i]) w_claim_id = 5'(i + 1);
    end
  end

  // Gateway next state: one request accepted per claim/complete round trip
  always_comb begin
    for (int i = 0; i < NUM_EXT; i++) begin
      w_gw_next[i] = r_gw[i];
      case (r_gw[i])
        StIdle:      if (ext_irq[i]) w_gw_next[i] = StPending;
        StPending:   if (w_claim_fire && (w_claim_id == 5'(i + 1))) w_gw_next[i] = StInService;
        StInService: if (w_cmpl && (d_in[4:0] == 5'(i + 1))) w_gw_next[i] = StIdle;
        default:     w_gw_next[i] = StIdle;
      endcase
    end
  end

  // Gateway state registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EXT; i++) begin
      if (rst) r_gw[i] <= StIdle;
      else     r_gw[i] <= w_gw_next[i];
    end
  end

  // Prescaler and mtime; a bus write to mtime swallows a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= 32'd0;
      r_mtime <= 64'd0;
    end else begin
      r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_wr && (w_reg == RegTimeLo))      r_mtime <= {r_mtime[63:32], d_in};
      else if (w_wr && (w_reg == RegTimeHi)) r_mtime <= {d_in, r_mtime[31:0]};
      else if (w_tick)                       r_mtime <= r_mtime + 64'd1;
    end
  end

  // Software-writable control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_enable   <= '0;
    end else if (w_wr) begin
      case (w_reg)
        RegMsip:   r_msip <= d_in[0];
        RegCmpLo:  r_mtimecmp[31:0] <= d_in;
        RegCmpHi:  r_mtimecmp[63:32] <= d_in;
        RegEnable: r_enable <= d_in[NUM_EXT-1:0];
        default:   ;
      endcase
    end
  end

  // Registered interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer_irq <= 1'b0;
      r_sw_irq    <= 1'b0;
      r_ext_irq   <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_sw_irq    <= r_msip;
      r_ext_irq   <= |(w_pending & r_enable);
    end
  end

`ifdef MTIME_SNAPSHOT_EN
  logic [31:0] r_time_shadow;

  // Capture the high word whenever the low word is read
  always_ff @(posedge clk) begin
    if (rst)                               r_time_shadow <= 32'd0;
    else if (w_wr && (w_reg == RegTimeHi)) r_time_shadow <= d_in;
    else if (w_rd && (w_reg == RegTimeLo)) r_time_shadow <= r_mtime[63:32];
  end

  assign w_time_hi_rd = r_time_shadow;
`else
  assign w_time_hi_rd = r_mtime[63:32];
`endif

  // Combinational read mux
  always_comb begin
    d_out = 32'd0;
    if (w_rd) begin
      case (w_reg)
        RegMsip:   d_out = {31'd0, r_msip};
        RegCmpLo:  d_out = r_mtimecmp[31:0];
        RegCmpHi:  d_out = r_mtimecmp[63:32];
        RegTimeLo: d_out = r_mtime[31:0];
        RegTimeHi: d_out = w_time_hi_rd;
        RegPend:   d_out = 32'(w_pending);
        RegEnable: d_out = 32'(r_enable);
        RegClaim:  d_out = 32'(w_claim_id);
        default:   d_out = 32'd0;
      endcase
    end
  end

  assign machineTimerInterrupt    = r_timer_irq;
  assign machineSoftwareInterrupt = r_sw_irq;
  assign machineExternalInterrupt = r_ext_irq;

endmodule

// File: tb/tb_machine_int_ctrl.sv
// Self-checking bench for machine_int_ctrl (NUM_EXT=8, PRESCALE=1).
// Inputs change on the falling edge; checks run 1 time unit later.
module tb_machine_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [4:0]  adr = 5'd0;
  logic [31:0] d_in = 32'd0;
  logic        mrd = 1'b0;
  logic        mwr = 1'b0;
  logic [31:0] d_out;
  logic [7:0]  ext_irq = 8'd0;
  logic        ti, si, ei;

  int n_checks = 0;
  int n_fail   = 0;

  machine_int_ctrl #(.NUM_EXT(8), .PRESCALE(1)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sel                      (sel),
    .adr                      (adr),
    .d_in                     (d_in),
    .mrd                      (mrd),
    .mwr                      (mwr),
    .d_out                    (d_out),
    .ext_irq                  (ext_irq),
    .machineTimerInterrupt    (ti),
    .machineSoftwareInterrupt (si),
    .machineExternalInterrupt (ei)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel, mrd, mwr;
    logic [4:0]  adr;
    logic [31:0] d;
    logic [7:0]  ext;
    logic [31:0] exp_dout;
    logic        exp_si, exp_ei;
  } vec_t;

  vec_t vecs [33];

  task automatic drive(input logic r, input logic s, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [31:0] d, input logic [7:0] e);
    @(negedge clk);
    rst = r; sel = s; mrd = rd; mwr = wr; adr = a; d_in = d; ext_irq = e;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_irqs(input string name, input logic et, input logic es, input logic ee);
    chk({name, ".timer"}, {31'd0, ti}, {31'd0, et});
    chk({name, ".soft"},  {31'd0, si}, {31'd0, es});
    chk({name, ".ext"},   {31'd0, ei}, {31'd0, ee});
  endtask

  initial begin
    logic [31:0] exp_hi;

    //             sel mrd mwr adr    d_in  ext    dout  si  ei
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'h00, 32'd1, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'd0, 8'h00, 32'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 5'h00, 32'd0, 8'h00, 32'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00, 32'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'h18, 32'd5, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h05, 32'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00, 32'd5, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00, 32'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00, 32'd3, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00, 32'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 5'h1C, 32'd1, 8'h01, 32'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h01, 32'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00, 32'd1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00, 32'd1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 5'h1C, 32'd3, 8'h00, 32'd0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 5'h1C, 32'd1, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 5'h18, 32'd0, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h08, 32'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h08, 32'd8, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h08, 32'd0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 5'h18, 32'd8, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00, 32'd0, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00, 32'd4, 1'b0, 1'b1};
    vecs[26] = '{1'b1, 1'b0, 1'b1, 5'h1C, 32'd4, 8'h08, 32'd0, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h08, 32'd0, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 1'b1, 1'b1, 5'h1C, 32'd0, 8'h00, 32'd4, 1'b0, 1'b0};
    vecs[29] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00, 32'd8, 1'b0, 1'b1};
    vecs[30] = '{1'b1, 1'b0, 1'b1, 5'h1C, 32'd4, 8'h00, 32'd0, 1'b0, 1'b1};
    vecs[31] = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00, 32'd8, 1'b0, 1'b1};
    vecs[32] = '{1'b1, 1'b1, 1'b0, 5'h1A, 32'd0, 8'h00, 32'd8, 1'b0, 1'b1};

    // Reset state
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'h04, 32'd0, 8'h00);
    chk("rst.cmp_lo", d_out, 32'hFFFF_FFFF);
    chk_irqs("rst", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'h08, 32'd0, 8'h00);
    chk("rst.cmp_hi", d_out, 32'hFFFF_FFFF);
    chk_irqs("rst2", 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h0C, 32'd0, 8'h00);
    chk("rel.mtime_lo", d_out, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h10, 32'd0, 8'h00);
    chk("rel.mtime_hi", d_out, 32'd0);

    // MSIP and external gateway vectors
    for (int i = 0; i < 33; i++) begin
      drive(1'b0, vecs[i].sel, vecs[i].mrd, vecs[i].mwr, vecs[i].adr, vecs[i].d, vecs[i].ext);
      chk($sformatf("vec%0d.dout", i), d_out, vecs[i].exp_dout);
      chk_irqs($sformatf("vec%0d", i), 1'b0, vecs[i].exp_si, vecs[i].exp_ei);
    end

    // Timer compare: mtime forced to 0, cmp = 20
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 32'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h0C, 32'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h08, 32'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h04, 32'd20, 8'h00);
    for (int k = 5; k <= 24; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h0C, 32'd0, 8'h00);
      chk($sformatf("tmr%0d.mtime", k), d_out, 32'(k - 3));
      chk($sformatf("tmr%0d.irq", k), {31'd0, ti}, {31'd0, (k - 4) >= 20});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h08, 32'd1, 8'h00);
    chk("tmr.cmp_hi_wr", {31'd0, ti}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00);
    chk("tmr.hold", {31'd0, ti}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00);
    chk("tmr.drop", {31'd0, ti}, 32'd0);

    // 64-bit wrap from all-ones
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 32'hFFFF_FFFF, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h0C, 32'hFFFF_FFFF, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h0C, 32'd0, 8'h00);
    chk("wrap.lo_ones", d_out, 32'hFFFF_FFFF);
`ifdef MTIME_SNAPSHOT_EN
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_hi = 32'd0;
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h10, 32'd0, 8'h00);
    chk("wrap.hi", d_out, exp_hi);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h0C, 32'd0, 8'h00);
    chk("wrap.lo", d_out, 32'd1);

    // Reset while a source is in service
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h18, 32'd2, 8'h02);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h1C, 32'd0, 8'h00);
    chk("rst6.claim", d_out, 32'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00);
    chk("rst6.pend_pre", d_out, 32'h08);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00);
    chk("rst6.pend_post", d_out, 32'd0);
    chk_irqs("rst6", 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h08, 32'd0, 8'h02);
    chk("rst6.cmp_hi", d_out, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 8'h00);
    chk("rst6.repend", d_out, 32'h02);

    // Split LO/HI read across a carry into the high word
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 32'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'h0C, 32'hFFFF_FFFF, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h0C, 32'd0, 8'h00);
    chk("snap.lo", d_out, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'd0, 8'h00);
`ifdef MTIME_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'h10, 32'd0, 8'h00);
    chk("snap.hi", d_out, exp_hi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
